// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter feeding one sync FIFO from NUM_REQ requesters.
// Round-robin by default; define FIFO_ARB_FIXED_PRIO_EN for fixed priority.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
   input  logic                          i_full,
   output logic                          o_wr_en,
   output logic [DATA_WIDTH-1:0]         o_wr_data,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic                          o_busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN) + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]         r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [IW-1:0]      r_gidx;
   logic [IW-1:0]      r_last;
   logic [CW-1:0]      r_cnt;

   logic [IW-1:0]      w_sel;
   logic               w_req_g;
   logic               w_beat;
   logic               w_last_beat;
   logic               w_release;

`ifdef FIFO_ARB_FIXED_PRIO_EN
   always_comb begin
      w_sel = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[IW'(i)]) w_sel = IW'(i);
      end
   end
`else
   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      int idx;
      w_sel = r_last;
      idx   = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(r_last) + i) % NUM_REQ;
         if (i_req[IW'(idx)]) w_sel = IW'(idx);
      end
   end
`endif

   assign w_req_g     = |(i_req & r_grant);
   assign w_beat      = w_req_g & ~i_full;
   assign w_last_beat = w_beat && (r_cnt == CW'(BURST_LEN - 1));
   assign w_release   = (r_state == S_GRANT) && (w_last_beat || !w_req_g);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(NUM_REQ - 1);
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|i_req) begin
                  r_state <= S_GRANT;
                  r_grant <= NUM_REQ'(1) << w_sel;
                  r_gidx  <= w_sel;
                  r_cnt   <= '0;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_state <= S_IDLE;
                  r_grant <= '0;
                  r_last  <= r_gidx;
                  r_cnt   <= '0;
               end else if (w_beat) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_busy    = (r_state == S_GRANT);
   assign o_grant   = r_grant;
   assign o_wr_en   = w_beat;
   assign o_ack     = w_beat ? r_grant : '0;
   assign o_wr_data = o_busy ?
                      i_data[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH] :
                      '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter (default parameters).
// Honours FIFO_ARB_FIXED_PRIO_EN in its reference model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int BL = 4;

   logic            clk;
   logic            i_rst;
   logic [N-1:0]    i_req;
   logic [N*DW-1:0] i_data;
   logic            i_full;
   logic            o_wr_en;
   logic [DW-1:0]   o_wr_data;
   logic [N-1:0]    o_ack;
   logic [N-1:0]    o_grant;
   logic            o_busy;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_req     (i_req),
      .i_data    (i_data),
      .i_full    (i_full),
      .o_wr_en   (o_wr_en),
      .o_wr_data (o_wr_data),
      .o_ack     (o_ack),
      .o_grant   (o_grant),
      .o_busy    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  grant;
      logic          busy;
      logic          wr;
      logic [N-1:0]  ack;
      logic [DW-1:0] data;
   } status_t;

   typedef struct {
      logic [N-1:0]  ack;
      logic [DW-1:0] data;
   } write_t;

   status_t sq[$];
   write_t  wq[$];

   int nchk = 0;
   int nfail = 0;
   int nwr = 0;
   int ng3 = 0;

   // reference model state: -1 owner means idle
   int owner = -1;
   int beats = 0;
   int last  = N - 1;
   int seq[N];

   function automatic int pick(input logic [N-1:0] req, input int lst);
      int k;
`ifdef FIFO_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (req[i]) return i;
`else
      for (int i = 1; i <= N; i++) begin
         k = (lst + i) % N;
         if (req[k]) return k;
      end
`endif
      return -1;
   endfunction

   function automatic logic [DW-1:0] word(input int k, input int s);
      return DW'(k * 256 + (s % 256));
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic [N-1:0] req, input logic full,
                        input logic rst);
      status_t s;
      write_t  w;
      logic    beat;
      @(posedge clk);
      #1;
      i_rst  = rst;
      i_req  = req;
      i_full = full;
      for (int k = 0; k < N; k++) i_data[k*DW +: DW] = word(k, seq[k]);
      s.grant = '0; s.busy = 1'b0; s.wr = 1'b0; s.ack = '0; s.data = '0;
      if (rst) begin
         owner = -1;
         beats = 0;
         last  = N - 1;
      end else if (owner < 0) begin
         if (req != 0) begin
            owner = pick(req, last);
            beats = 0;
         end
      end else begin
         s.grant = N'(1) << owner;
         s.busy  = 1'b1;
         s.data  = word(owner, seq[owner]);
         beat    = req[owner] && !full;
         if (beat) begin
            s.wr  = 1'b1;
            s.ack = s.grant;
            w.ack = s.grant;
            w.data = s.data;
            wq.push_back(w);
            seq[owner]++;
            beats++;
         end
         if ((beat && beats == BL) || !req[owner]) begin
            last  = owner;
            owner = -1;
         end
      end
      sq.push_back(s);
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      status_t s;
      write_t  w;
      if (sq.size() > 0) begin
         s = sq.pop_front();
         check("grant", DW'(o_grant), DW'(s.grant));
         check("busy",  DW'(o_busy),  DW'(s.busy));
         check("wr_en", DW'(o_wr_en), DW'(s.wr));
         check("ack",   DW'(o_ack),   DW'(s.ack));
         check("wr_data", o_wr_data, s.data);
      end
      if (o_grant[3]) ng3++;
      if (o_wr_en) begin
         nwr++;
         if (wq.size() == 0) begin
            check("unexpected_write", DW'(1), DW'(0));
         end else begin
            w = wq.pop_front();
            check("fifo_ack", DW'(o_ack), DW'(w.ack));
            check("fifo_data", o_wr_data, w.data);
         end
      end
      if (wq.size() != 0) begin
         check("missed_write", DW'(wq.size()), DW'(0));
         wq.delete();
      end
   end

   initial begin
      int w0;
      logic [N-1:0] rq;
      logic fl, rs;
      for (int k = 0; k < N; k++) seq[k] = 0;
      i_rst  = 1'b1;
      i_req  = '0;
      i_full = 1'b0;
      i_data = '0;

      cycle('0, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b1);
      check("reset_grant", DW'(o_grant), DW'(0));
      check("reset_wr_en", DW'(o_wr_en), DW'(0));
      cycle('0, 1'b0, 1'b0);

      // four requesters held: 16 writes in 20 cycles
      w0 = nwr;
      repeat (20) cycle(4'b1111, 1'b0, 1'b0);
      check("rr_write_count", DW'(nwr - w0), DW'(16));
      cycle('0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);

      // short burst dropped after two beats
      w0 = nwr;
      repeat (3) cycle(4'b0100, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);
      check("short_burst_count", DW'(nwr - w0), DW'(2));
      cycle('0, 1'b0, 1'b0);
      check("short_burst_idle", DW'(o_grant), DW'(0));

      // full stall mid-burst for requester 1
      w0 = nwr;
      repeat (3) cycle(4'b0010, 1'b0, 1'b0);
      repeat (5) cycle(4'b0010, 1'b1, 1'b0);
      check("stall_count", DW'(nwr - w0), DW'(2));
      repeat (2) cycle(4'b0010, 1'b0, 1'b0);
      check("stall_resume_count", DW'(nwr - w0), DW'(4));
      cycle('0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);

      // reset during beat 2 of requester 2
      repeat (3) cycle(4'b0100, 1'b0, 1'b0);
      cycle(4'b0100, 1'b0, 1'b1);
      check("midreset_grant", DW'(o_grant), DW'(0));
      check("midreset_wr_en", DW'(o_wr_en), DW'(0));
      cycle(4'b1111, 1'b0, 1'b0);
      cycle(4'b1111, 1'b0, 1'b0);
      check("post_reset_grant", DW'(o_grant), DW'(4'b0001));
      cycle('0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
      ng3 = 0;
      repeat (30) cycle(4'b1010, 1'b0, 1'b0);
      check("fixed_prio_no_req3", DW'(ng3), DW'(0));
      cycle('0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);
`endif

      rq = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++)
            if ($urandom_range(7) == 0) rq[k] = ~rq[k];
         fl = ($urandom_range(3) == 0);
         rs = ($urandom_range(199) == 0);
         cycle(rq, fl, rs);
      end
      cycle('0, 1'b0, 1'b0);
      check("status_queue_drained", DW'(sq.size()), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of each requester's write data.
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_req  input  NUM_REQ  per-requester write request; bit k means requester k holds valid data.
REQ-007 SHALL have port i_data  input  NUM_REQ*DATA_WIDTH  flattened requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port i_full  input  1  full flag from the downstream sync FIFO.
REQ-009 SHALL have port o_wr_en  output  1  write enable to the FIFO.
REQ-010 SHALL have port o_wr_data  output  DATA_WIDTH  write data to the FIFO.
REQ-011 SHALL have port o_ack  output  NUM_REQ  per-requester beat accepted; the requester advances its data on the same edge.
REQ-012 SHALL have port o_grant  output  NUM_REQ  one-hot registered grant; all-zero when idle.
REQ-013 SHALL have port o_busy  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 In IDLE with i_req != 0, SHALL select one requester and, on the next edge, load o_grant with it and enter GRANT; arbitration costs exactly one idle cycle.
REQ-016 In IDLE with i_req == 0, SHALL remain in IDLE with o_grant = 0.
REQ-017 Selection SHALL be round-robin: search starts at (last_grant + 1) mod NUM_REQ and wraps; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-018 In GRANT for requester g, a beat SHALL occur in any cycle where i_req[g] = 1 and i_full = 0.
REQ-019 o_wr_en and o_ack[g] SHALL be combinational and equal to the beat condition; o_ack bits of non-granted requesters SHALL be 0.
REQ-020 o_wr_data SHALL equal requester g's data slice while in GRANT and zero in IDLE.
REQ-021 A beat counter of width $clog2(BURST_LEN)+1 SHALL clear on grant and increment on each beat.
REQ-022 GRANT SHALL release to IDLE on the edge where the BURST_LEN-th beat occurs, or on any edge where i_req[g] = 0; last_grant SHALL update to g on release.
REQ-023 While i_full = 1, SHALL hold the grant, issue no beats, and freeze the beat counter; no timeout.
REQ-024 When only one requester asserts, after each release it SHALL be re-granted after the one IDLE cycle.
REQ-025 Requests from non-granted requesters SHALL never affect the current grant.

Reset
REQ-026 On i_rst = 1, SHALL asynchronously force state IDLE, o_grant = 0, beat counter = 0, last_grant = NUM_REQ-1.
REQ-027 During reset, o_wr_en, o_ack, o_busy SHALL be 0 and o_wr_data zero; a burst interrupted by reset SHALL not resume.
REQ-028 After deassertion, first arbitration SHALL occur on the first edge with i_req != 0.

Configuration
REQ-029 Macro FIFO_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority (lowest index wins), ignoring last_grant.
REQ-030 Without FIFO_ARB_FIXED_PRIO_EN, round-robin per REQ-017 SHALL apply; ports and all other behaviour are identical in both builds.

Verification
REQ-031 Reset then i_req=4'b1111 held, i_full=0, BURST_LEN=4 -> grants 0,1,2,3,0 in order, each 4 beats then 1 idle cycle; 16 writes per 20 cycles.
REQ-032 i_req=4'b0100 for 2 beats then deassert -> o_grant=4'b0100, two o_wr_en pulses, release after the 2nd, o_grant=0 next cycle.
REQ-033 Grant to req 1, i_full=1 for 5 cycles after beat 2 -> no o_wr_en/o_ack for 5 cycles; beats 3-4 follow once i_full=0; release after beat 4.
REQ-034 i_rst pulsed mid-burst (beat 2 of req 2) -> o_grant=0, o_wr_en=0 immediately; next grant with i_req=4'b1111 goes to req 0.
REQ-035 FIFO_ARB_FIXED_PRIO_EN defined, i_req=4'b1010 held -> req 1 granted every time, req 3 never.
REQ-036 Data check: requester k drives k*256+beat; FIFO content matches grant order and beat sequence exactly, no loss or duplication.
